shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_step.sv | 27 ++
 rtl/shift_add_multiplier.sv | 110 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier: FSM state encoding and the
// width helper for the step counter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold every value from 0 to n/k.
  function automatic int cnt_w(input int n, input int k);
    return $clog2(n / k + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^K step: magnitude A times a K-bit digit, shifted to the digit's
// offset and added into the 2N-bit accumulator. Purely combinational.
module mult_step
  import mult_pkg::*;
#(
  parameter int N  = 32,
  parameter int K  = 1,
  parameter int CW = cnt_w(N, K)
) (
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   mag_a,
  input  logic [K-1:0]   digit,
  input  logic [CW-1:0]  count,
  output logic [2*N-1:0] acc_next
);

  localparam int OW = $clog2(2 * N);

  logic [N+K-1:0] partial;
  logic [OW-1:0]  offset;

  // Full-width partial product; the offset never exceeds N-K so nothing is lost.
  assign partial  = (N+K)'(mag_a) * (N+K)'(digit);
  assign offset   = OW'(count) * OW'(K);
  assign acc_next = acc + ((2*N)'(partial) << offset);

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative signed/unsigned N x N multiplier retiring K multiplier bits per cycle;
// accept-to-out_valid latency is N/K+1 cycles and the product holds in DONE until out_ready.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = cnt_w(N, K);
  localparam logic [CW-1:0] LAST = CW'(N / K - 1);

  if (N < 2 || K < 1 || (N % K) != 0) begin : g_bad_param
    $error("shift_add_multiplier: N must be >= 2 and K must divide N");
  end

  state_t          state;
  logic [N-1:0]    mag_a;
  logic [N-1:0]    mplier;
  logic            neg;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  acc_next;
  logic [N-1:0]    abs_a;
  logic [N-1:0]    abs_b;

  // Two's-complement negation of the most negative value yields 2^(N-1) unsigned.
  assign abs_a = (is_signed && multiplicand[N-1]) ? -multiplicand : multiplicand;
  assign abs_b = (is_signed && multiplier[N-1])   ? -multiplier   : multiplier;

  mult_step #(
    .N  (N),
    .K  (K),
    .CW (CW)
  ) u_step (
    .acc      (acc),
    .mag_a    (mag_a),
    .digit    (mplier[K-1:0]),
    .count    (count),
    .acc_next (acc_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      acc       <= '0;
      count     <= '0;
      mag_a     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a    <= abs_a;
            mplier   <= abs_b;
            neg      <= is_signed & (multiplicand[N-1] ^ multiplier[N-1]);
            acc      <= '0;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> K;
          count  <= count + CW'(1);
          if (count == LAST) begin
            // A zero magnitude negates to zero, so no sign artefact escapes.
            product   <= neg ? -acc_next : acc_next;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
